wb_rr_arbiter: RTL and testbench

- Round-robin Wishbone arbiter that shares one slave port (e.g. the GPIO controller at 0x8000_1000) between NUM_MASTERS bus masters, such as the CPU data port and a DMA/debug master.
- Grant is locked for a whole bus tenure, i.e. while the owner holds cyc.
- An optional watchdog aborts tenures whose slave never acks.
- Sits between the masters and the address decoder/slave in the SoC interconnect.

---
 rtl/wb_arb_pkg.sv | 25 ++
 rtl/wb_rr_arbiter_rr_picker.sv | 18 +
 rtl/wb_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_wb_rr_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types, default widths and round-robin helper for Wishbone arbiters
package wb_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
    localparam int DEF_NUM_MASTERS = 2;
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;
    localparam int MAX_MASTERS = 8;
    localparam int IW = 3;
    typedef logic [IW-1:0] idx_t;

    // First set bit of req searching from ptr+1, wrapping modulo n; returns ptr when req is empty.
    function automatic idx_t rr_next(input logic [MAX_MASTERS-1:0] req, input idx_t ptr, input int n);
        idx_t idx;
        logic found;
        rr_next = ptr;
        found = 1'b0;
        for (int k = 1; k <= MAX_MASTERS; k++) begin
            idx = idx_t'((int'(ptr) + k) % n);
            if (!found && k <= n && req[idx]) begin
                rr_next = idx;
                found = 1'b1;
            end
        end
    endfunction
endpackage

// File: rtl/wb_rr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of one requester after the pointer
module rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N = DEF_NUM_MASTERS
) (
    input  logic [N-1:0] req,
    input  idx_t         ptr,
    output logic [N-1:0] gnt,
    output idx_t         idx,
    output logic         valid
);
    always_comb begin
        valid = |req;
        idx = rr_next(MAX_MASTERS'(req), ptr, N);
        gnt = valid ? N'(1) << idx : '0;
    end
endmodule

// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin Wishbone arbiter, grant locked for a whole cyc tenure.
// Define WB_ARB_TIMEOUT_EN to add the no-ack watchdog with error pulse and DRAIN state.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = DEF_NUM_MASTERS,
    parameter int AW             = DEF_AW,
    parameter int DW             = DEF_DW,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
    output logic [DW-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    input  logic [DW-1:0]             s_dat_i,
    input  logic                      s_ack_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);
    if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES < 1)
        $error("wb_rr_arbiter: unsupported NUM_MASTERS or TIMEOUT_CYCLES");

    state_t state, state_n;
    logic [NUM_MASTERS-1:0] grant, grant_n, pick_gnt;
    idx_t rr_ptr, ptr_n, pick_idx;
    logic pick_valid, live, sel_cyc, sel_stb, sel_we;
    logic [AW-1:0] sel_adr;
    logic [DW-1:0] sel_dat;
`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic [NUM_MASTERS-1:0] err, err_n;
`endif

    rr_picker #(.N(NUM_MASTERS)) u_pick (
        .req(m_cyc_i), .ptr(rr_ptr), .gnt(pick_gnt), .idx(pick_idx), .valid(pick_valid)
    );

    // rr_ptr doubles as the owner index while a grant is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            rr_ptr <= idx_t'(NUM_MASTERS - 1);
        end else begin
            state <= state_n;
            grant <= grant_n;
            rr_ptr <= ptr_n;
        end
    end

    always_comb begin
        state_n = state;
        grant_n = grant;
        ptr_n = rr_ptr;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_n = '0;
        err_n = '0;
`endif
        if (state == IDLE) begin
            if (pick_valid) begin
                state_n = BUSY;
                grant_n = pick_gnt;
                ptr_n = pick_idx;
            end
        end else if (!sel_cyc) begin
            state_n = IDLE;
            grant_n = '0;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (state == BUSY && sel_stb && !s_ack_i) begin
            if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                state_n = DRAIN;
                err_n = grant;
            end else begin
                cnt_n = cnt + 1'b1;
            end
        end
`endif
    end

    always_comb begin
        sel_adr = '0;
        sel_dat = '0;
        sel_we = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant[i]) begin
                sel_adr = m_adr_i[i*AW +: AW];
                sel_dat = m_dat_i[i*DW +: DW];
                sel_we = m_we_i[i];
            end
        end
        sel_cyc = |(m_cyc_i & grant);
        sel_stb = |(m_stb_i & grant);
        live = state == BUSY;
        s_cyc_o = live & sel_cyc;
        s_stb_o = live & sel_stb;
        s_we_o = live & sel_we;
        s_adr_o = sel_adr;
        s_dat_o = sel_dat;
        m_ack_o = (live && s_ack_i) ? grant : '0;
        m_dat_o = s_dat_i;
        grant_o = grant;
    end

`ifdef WB_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            err <= '0;
        end else begin
            cnt <= cnt_n;
            err <= err_n;
        end
    end
    assign m_err_o = err;
`else
    assign m_err_o = '0;
`endif
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// tb_wb_rr_arbiter: vector table, directed corner sequences and randomized model check
module tb_wb_rr_arbiter;
    localparam int N = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TMO = 4;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] cyc = '0, stb = '0, we = '0;
    logic [N*AW-1:0] m_adr = '0;
    logic [N*DW-1:0] m_dat = '0;
    logic [DW-1:0] m_dat_o, s_dat_o, s_dat = '0;
    logic [N-1:0] m_ack_o, m_err_o, grant_o;
    logic s_cyc_o, s_stb_o, s_we_o, s_ack = 1'b0;
    logic [AW-1:0] s_adr_o;
    int n_chk = 0, n_fail = 0;

    typedef struct {
        logic [1:0] cyc;
        logic       ack;
        logic [1:0] gnt;
        logic       scyc;
        logic [1:0] mack;
    } vec_t;
    vec_t vec [19];

    wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .m_cyc_i(cyc), .m_stb_i(stb), .m_we_i(we),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
        .m_err_o(m_err_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat), .s_ack_i(s_ack),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic pulse_rst;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    int owner, last, run, o;
    logic drain, live;
    logic [1:0] err_m, e_gnt;

    initial begin
        vec = '{
            '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00},
            '{2'b11, 1'b1, 2'b01, 1'b1, 2'b01},
            '{2'b10, 1'b0, 2'b01, 1'b0, 2'b00},
            '{2'b10, 1'b0, 2'b00, 1'b0, 2'b00},
            '{2'b10, 1'b1, 2'b10, 1'b1, 2'b10},
            '{2'b01, 1'b0, 2'b10, 1'b0, 2'b00},
            '{2'b01, 1'b0, 2'b00, 1'b0, 2'b00},
            '{2'b01, 1'b1, 2'b01, 1'b1, 2'b01},
            '{2'b00, 1'b0, 2'b01, 1'b0, 2'b00},
            '{2'b00, 1'b0, 2'b00, 1'b0, 2'b00},
            '{2'b11, 1'b0, 2'b00, 1'b0, 2'b00},
            '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10},
            '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10},
            '{2'b11, 1'b1, 2'b10, 1'b1, 2'b10},
            '{2'b01, 1'b0, 2'b10, 1'b0, 2'b00},
            '{2'b01, 1'b0, 2'b00, 1'b0, 2'b00},
            '{2'b01, 1'b0, 2'b01, 1'b1, 2'b00},
            '{2'b00, 1'b0, 2'b01, 1'b0, 2'b00},
            '{2'b00, 1'b0, 2'b00, 1'b0, 2'b00}
        };
        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", grant_o, 0);
        chk("rst_scyc", {s_cyc_o, s_stb_o}, 0);
        chk("rst_ack_err", {m_ack_o, m_err_o}, 0);
        // single write from master 0
        tick;
        rst = 1'b0;
        cyc = 2'b01; stb = 2'b01; we = 2'b01;
        m_adr[31:0] = 32'h8000_1004; m_dat[31:0] = 32'h0000_A5A5;
        @(negedge clk);
        chk("wr_latency_scyc", s_cyc_o, 0);
        tick;
        @(negedge clk);
        chk("wr_grant", grant_o, 2'b01);
        chk("wr_ctl", {s_cyc_o, s_stb_o, s_we_o}, 3'b111);
        chk("wr_adr", s_adr_o, 32'h8000_1004);
        chk("wr_dat", s_dat_o, 32'h0000_A5A5);
        tick;
        s_ack = 1'b1; s_dat = 32'h1234_5678;
        @(negedge clk);
        chk("wr_ack", m_ack_o, 2'b01);
        chk("rd_dat_bcast", m_dat_o, 32'h1234_5678);
        tick;
        cyc = '0; stb = '0; we = '0; s_ack = 1'b0;
        @(negedge clk);
        chk("wr_rel_scyc", {grant_o, s_cyc_o}, 3'b010);
        tick;
        @(negedge clk);
        chk("wr_idle_grant", grant_o, 0);
        // rotation and held tenure, from fresh priority
        pulse_rst;
        m_adr = {2{32'h8000_1000}};
        for (int i = 0; i < 19; i++) begin
            tick;
            cyc = vec[i].cyc; stb = vec[i].cyc; s_ack = vec[i].ack;
            @(negedge clk);
            chk($sformatf("vec%0d_grant", i), grant_o, vec[i].gnt);
            chk($sformatf("vec%0d_scyc", i), s_cyc_o, vec[i].scyc);
            chk($sformatf("vec%0d_ack", i), m_ack_o, vec[i].mack);
        end
        // reset mid-tenure while master 1 owns the bus
        tick;
        cyc = 2'b10; stb = 2'b10; s_ack = 1'b0;
        tick;
        @(negedge clk);
        chk("mid_grant", grant_o, 2'b10);
        chk("mid_sstb", s_stb_o, 1);
        #1 rst = 1'b1;
        cyc = 2'b11; stb = 2'b11;
        #1;
        chk("mid_rst_scyc", {s_cyc_o, s_stb_o}, 0);
        chk("mid_rst_grant", grant_o, 0);
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", grant_o, 0);
        tick;
        @(negedge clk);
        chk("post_rst_prio", grant_o, 2'b01);
        // stalled slave: watchdog when enabled, indefinite hold otherwise
        tick;
        cyc = '0; stb = '0;
        pulse_rst;
        cyc = 2'b01; stb = 2'b01;
        for (int k = 0; k < 9; k++) begin
            tick;
            @(negedge clk);
            chk($sformatf("stall%0d_grant", k), grant_o, 2'b01);
            chk($sformatf("stall%0d_scyc", k), s_cyc_o, (TO_EN && k >= TMO) ? 1'b0 : 1'b1);
            chk($sformatf("stall%0d_err", k), m_err_o, (TO_EN && k == TMO) ? 2'b01 : 2'b00);
        end
        tick;
        s_ack = 1'b1;
        @(negedge clk);
        chk("stall_ack", m_ack_o, TO_EN ? 2'b00 : 2'b01);
        tick;
        cyc = '0; stb = '0; s_ack = 1'b0;
        tick;
        @(negedge clk);
        chk("stall_exit", grant_o, 0);
        // randomized traffic against the reference model
        pulse_rst;
        owner = -1; last = N - 1; run = 0; drain = 1'b0; err_m = '0;
        for (int n = 0; n < 400; n++) begin
            tick;
            for (int i = 0; i < N; i++) begin
                cyc[i] = $urandom_range(0, 9) < 8;
                stb[i] = cyc[i] && ($urandom_range(0, 2) != 0);
            end
            we = 2'($urandom);
            m_adr = {$urandom, $urandom};
            m_dat = {$urandom, $urandom};
            s_dat = $urandom;
            s_ack = $urandom_range(0, 3) == 0;
            @(negedge clk);
            o = owner < 0 ? 0 : owner;
            live = owner >= 0 && !drain;
            e_gnt = owner >= 0 ? 2'(1 << owner) : 2'b00;
            chk("rnd_grant", grant_o, e_gnt);
            chk("rnd_ctl", {s_cyc_o, s_stb_o, s_we_o}, {live && cyc[o], live && stb[o], live && we[o]});
            chk("rnd_adr_dat", {s_adr_o, s_dat_o}, owner >= 0 ? {m_adr[o*AW +: AW], m_dat[o*DW +: DW]} : 64'd0);
            chk("rnd_ack", m_ack_o, (live && s_ack) ? e_gnt : 2'b00);
            chk("rnd_err", m_err_o, err_m);
            err_m = '0;
            if (owner < 0) begin
                for (int k = 1; k <= N; k++)
                    if (owner < 0 && cyc[(last + k) % N]) owner = (last + k) % N;
                if (owner >= 0) last = owner;
                run = 0;
            end else if (!cyc[owner]) begin
                owner = -1; drain = 1'b0; run = 0;
            end else if (TO_EN && !drain && stb[owner] && !s_ack) begin
                run++;
                if (run == TMO) begin
                    drain = 1'b1; err_m = 2'(1 << owner); run = 0;
                end
            end else begin
                run = 0;
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
